// File: rtl/regfile_sb.sv
// regfile_sb - parametrised pipeline register file with a pending-write
// scoreboard and a post-reset clear sequencer.
//
// Two combinational read ports with write-first bypass, one write port, and
// one pending bit per register that tells the ID stage a result is still in
// flight. After reset the array is zeroed one entry per cycle; ready rises
// once every entry has been cleared.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   defined   : register 0 reads as zero, ignores writes, never goes pending
//   undefined : register 0 is an ordinary register
//
// Parameters:
//   DATA_W  data width in bits
//   DEPTH   number of registers (power of 2, >= 2)
//   ADDR_W  derived address width, $clog2(DEPTH)
//
// Ports:
//   clk     clock, all state updates on the rising edge
//   rst_n   synchronous active-low reset
//   rn1/rn2 read addresses          rd1/rd2   read data
//   pend1/pend2 read register has an outstanding write
//   we, wn, wd  writeback port
//   iss_en, iss_wn  issue of an instruction writing iss_wn
//   ready   array cleared, block accepting traffic
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rn1,
   input  logic [ADDR_W-1:0] rn2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              pend1,
   output logic              pend2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wn,
   input  logic [DATA_W-1:0] wd,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_wn,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [DEPTH-1:0]    pend;
   logic [DEPTH-1:0]    pend_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_ok;
   logic                iss_ok;

`ifdef REGFILE_ZERO_REG_EN
   assign wr_ok  = we && (wn != '0);
   assign iss_ok = iss_en && (iss_wn != '0);
`else
   assign wr_ok  = we;
   assign iss_ok = iss_en;
`endif

   // Control: state, clear counter, ready and scoreboard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= INIT;
         clr_cnt <= '0;
         pend    <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               clr_cnt <= clr_cnt + ADDR_W'(1);
               if (clr_cnt == CLR_LAST) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               pend <= pend_nxt;
            end
            default: state <= INIT;
         endcase
      end
   end

   // Clear before set: an issue in the same cycle as a writeback to the same
   // register is the younger producer and must stay outstanding.
   always_comb begin
      pend_nxt = pend;
      if (we)
         pend_nxt[wn] = 1'b0;
      if (iss_ok)
         pend_nxt[iss_wn] = 1'b1;
   end

   // Array: no reset on data; INIT zeroes one entry per cycle.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT)
            mem[clr_cnt] <= '0;
         else if (wr_ok)
            mem[wn] <= wd;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] rn);
      logic [DATA_W-1:0] val;
      if (state != RUN)
         val = '0;
`ifdef REGFILE_ZERO_REG_EN
      else if (rn == '0)
         val = '0;
`endif
      else if (we && (wn == rn))
         val = wd;
      else
         val = mem[rn];
      return val;
   endfunction

   // Issue visibility wins over a matching writeback so a back-to-back
   // dependent instruction stalls on the fresh producer.
   function automatic logic pend_port(input logic [ADDR_W-1:0] rn);
      logic val;
      if (state != RUN)
         val = 1'b0;
      else if (iss_ok && (iss_wn == rn))
         val = 1'b1;
      else if (we && (wn == rn))
         val = 1'b0;
      else
         val = pend[rn];
      return val;
   endfunction

   always_comb begin
      rd1   = read_port(rn1);
      rd2   = read_port(rn2);
      pend1 = pend_port(rn1);
      pend2 = pend_port(rn2);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb - directed self-checking bench for regfile_sb (DEPTH=16,
// DATA_W=32). Expected values are hand-computed constants.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic [3:0]  rn1, rn2, wn, iss_wn;
   logic [31:0] rd1, rd2, wd;
   logic        pend1, pend2, we, iss_en, ready;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_sb #(.DATA_W(32), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .rn1(rn1), .rn2(rn2), .rd1(rd1), .rd2(rd2),
      .pend1(pend1), .pend2(pend2),
      .we(we), .wn(wn), .wd(wd),
      .iss_en(iss_en), .iss_wn(iss_wn),
      .ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] zr_rd;
      logic        zr_pend;
`ifdef REGFILE_ZERO_REG_EN
      zr_rd   = 32'h0;
      zr_pend = 1'b0;
`else
      zr_rd   = 32'h0000AABB;
      zr_pend = 1'b1;
`endif
      rst_n = 1'b0; we = 1'b0; iss_en = 1'b0;
      rn1 = '0; rn2 = '0; wn = '0; iss_wn = '0; wd = '0;
      tick();
      tick();
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_rd1", rd1, 32'h0);
      check("reset_pend1", 32'(pend1), 32'h0);

      // Release reset; drive traffic that INIT must ignore.
      rst_n = 1'b1;
      we = 1'b1; wn = 4'd3; wd = 32'hDEADBEEF;
      iss_en = 1'b1; iss_wn = 4'd3;
      rn1 = 4'd3;
      #1;
      check("init_rd1_forced", rd1, 32'h0);
      check("init_pend1_forced", 32'(pend1), 32'h0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 16) begin
            we = 1'b0; iss_en = 1'b0;
         end
         check($sformatf("clr_ready_%0d", i), 32'(ready), (i == 16) ? 32'h1 : 32'h0);
      end

      for (int a = 0; a < 16; a++) begin
         rn1 = 4'(a); rn2 = 4'(15 - a);
         #1;
         check($sformatf("clr_rd1_%0d", a), rd1, 32'h0);
         check($sformatf("clr_rd2_%0d", a), rd2, 32'h0);
         check($sformatf("clr_pend1_%0d", a), 32'(pend1), 32'h0);
      end

      // Write then read, with same-cycle bypass on port 2.
      rn1 = 4'd0; rn2 = 4'd5;
      we = 1'b1; wn = 4'd5; wd = 32'h000BACC1;
      #1;
      check("bypass_rd2", rd2, 32'h000BACC1);
      tick();
      we = 1'b0; rn1 = 4'd5;
      #1;
      check("wr_rd1", rd1, 32'h000BACC1);
      check("wr_rd2", rd2, 32'h000BACC1);

      // Scoreboard hazard on register 7.
      iss_en = 1'b1; iss_wn = 4'd7; rn1 = 4'd7;
      #1;
      check("iss_pend1_comb", 32'(pend1), 32'h1);
      tick();
      iss_en = 1'b0;
      #1;
      check("pend1_held_a", 32'(pend1), 32'h1);
      tick();
      check("pend1_held_b", 32'(pend1), 32'h1);
      we = 1'b1; wn = 4'd7; wd = 32'h00000077;
      #1;
      check("wb_pend1_comb", 32'(pend1), 32'h0);
      check("wb_rd1_bypass", rd1, 32'h00000077);
      tick();
      we = 1'b0;
      #1;
      check("wb_pend1_after", 32'(pend1), 32'h0);
      check("wb_rd1_after", rd1, 32'h00000077);

      // Simultaneous issue and writeback on register 4: set wins.
      rn1 = 4'd4;
      we = 1'b1; wn = 4'd4; wd = 32'h00000044;
      iss_en = 1'b1; iss_wn = 4'd4;
      #1;
      check("both_pend1_comb", 32'(pend1), 32'h1);
      check("both_rd1_bypass", rd1, 32'h00000044);
      tick();
      we = 1'b0; iss_en = 1'b0;
      #1;
      check("both_pend1_after", 32'(pend1), 32'h1);
      check("both_rd1_after", rd1, 32'h00000044);
      we = 1'b1; wn = 4'd4; wd = 32'h00001034;
      tick();
      we = 1'b0;
      #1;
      check("r4_pend1_clr", 32'(pend1), 32'h0);
      check("r4_rd1", rd1, 32'h00001034);

      // Leave register 9 pending for the mid-run reset.
      iss_en = 1'b1; iss_wn = 4'd9;
      tick();
      iss_en = 1'b0; rn2 = 4'd9;
      #1;
      check("r9_pend2", 32'(pend2), 32'h1);

      // Register 0 behaviour.
      rn1 = 4'd0;
      we = 1'b1; wn = 4'd0; wd = 32'h0000AABB;
      #1;
      check("r0_rd1_bypass", rd1, zr_rd);
      tick();
      we = 1'b0;
      #1;
      check("r0_rd1", rd1, zr_rd);
      iss_en = 1'b1; iss_wn = 4'd0;
      #1;
      check("r0_pend1_comb", 32'(pend1), 32'(zr_pend));
      tick();
      iss_en = 1'b0;
      #1;
      check("r0_pend1", 32'(pend1), 32'(zr_pend));

      // Mid-run reset.
      rst_n = 1'b0;
      tick();
      check("mid_rst_ready", 32'(ready), 32'h0);
      rst_n = 1'b1; rn1 = 4'd4; rn2 = 4'd9;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("mid_ready_%0d", i), 32'(ready), (i == 16) ? 32'h1 : 32'h0);
      end
      check("mid_rd1", rd1, 32'h0);
      check("mid_rd2", rd2, 32'h0);
      check("mid_pend1", 32'(pend1), 32'h0);
      check("mid_pend2", 32'(pend2), 32'h0);
      rn1 = 4'd0;
      #1;
      check("mid_r0_pend1", 32'(pend1), 32'h0);
      check("mid_r0_rd1", rd1, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
